// File: rtl/ipg_rx_packer.sv
// Zeroes the inter-packet-gap lanes of 64b/66b control blocks and packs the extracted bytes into OUT_WIDTH words behind a small FIFO.
// Optional: define IPG_RX_DROP_CNT_EN to enable the saturating drop counter.
module ipg_rx_packer #(
    parameter int OUT_WIDTH  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:0]                     encoded_rx_hdr,
    input  logic [63:0]                    encoded_rx_data,
    input  logic                           flush,
    output logic [1:0]                     recovered_rx_hdr,
    output logic [63:0]                    recovered_rx_data,
    output logic [OUT_WIDTH-1:0]           m_data,
    output logic [$clog2(OUT_WIDTH/8):0]   m_bytes,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [15:0]                    drop_cnt
);
    localparam int NB = OUT_WIDTH / 8;
    localparam int BW = $clog2(NB) + 1;
    localparam int FW = BW + 1;
    localparam int AW = OUT_WIDTH + 56;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [FW-1:0] NB_F = FW'(NB);

    // Extracted lanes are always one contiguous run: returns {first lane, lane count}
    function automatic logic [6:0] lane_decode(input logic [7:0] btype);
        logic [6:0] r;
        case (btype)
            8'h1e:        r = {3'd1, 4'd7};
            8'h2d, 8'h33: r = {3'd1, 4'd3};
            8'h4b, 8'hb4: r = {3'd5, 4'd3};
            8'h87:        r = {3'd2, 4'd6};
            8'h99:        r = {3'd3, 4'd5};
            8'haa:        r = {3'd4, 4'd4};
            8'hcc:        r = {3'd6, 4'd2};
            8'hd2:        r = {3'd7, 4'd1};
            default:      r = 7'd0;
        endcase
        return r;
    endfunction

    logic [2:0]           ext_lo_s;
    logic [3:0]           ext_cnt_s;
    logic [55:0]          shifted_s;
    logic [55:0]          ext_s;
    logic [63:0]          rdata_s;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [BW-1:0]        fill_q, fill_d;
    logic                 pend_q, pend_d;
    logic [FW-1:0]        total_s;
    logic [AW-1:0]        comb_s;
    logic                 flush_req_s;
    logic                 push_s;
    logic [OUT_WIDTH-1:0] push_data_s;
    logic [BW-1:0]        push_bytes_s;
    logic [1:0]           rhdr_q;
    logic [63:0]          rdata_q;

    logic [OUT_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [BW-1:0]        mem_bytes_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 valid_q;
    logic                 pop_s, full_s, wr_en_s;

    // Lane decode, compaction of extracted bytes and lane zeroing
    always_comb begin
        if (encoded_rx_hdr == 2'b01) begin
            {ext_lo_s, ext_cnt_s} = lane_decode(encoded_rx_data[7:0]);
        end else begin
            {ext_lo_s, ext_cnt_s} = 7'd0;
        end
        shifted_s = encoded_rx_data[63:8] >> {ext_lo_s - 3'd1, 3'b000};
        ext_s     = 56'd0;
        rdata_s   = encoded_rx_data;
        for (int i = 0; i < 8; i++) begin
            if ((4'(i) >= {1'b0, ext_lo_s}) && (4'(i) < ({1'b0, ext_lo_s} + ext_cnt_s))) begin
                rdata_s[8*i +: 8] = 8'h00;
            end else begin
                rdata_s[8*i +: 8] = encoded_rx_data[8*i +: 8];
            end
        end
        for (int i = 0; i < 7; i++) begin
            if (4'(i) < ext_cnt_s) begin
                ext_s[8*i +: 8] = shifted_s[8*i +: 8];
            end else begin
                ext_s[8*i +: 8] = 8'h00;
            end
        end
    end

    // Accumulator append, full-word split and flush handling; at most one push per cycle
    always_comb begin
        total_s      = FW'(fill_q) + FW'(ext_cnt_s);
        comb_s       = {56'd0, acc_q} | ({{OUT_WIDTH{1'b0}}, ext_s} << {fill_q, 3'b000});
        flush_req_s  = flush | pend_q;
        pend_d       = flush_req_s & (ext_cnt_s != 4'd0);
        push_s       = 1'b0;
        push_data_s  = {OUT_WIDTH{1'b0}};
        push_bytes_s = {BW{1'b0}};
        acc_d        = acc_q;
        fill_d       = fill_q;
        if (total_s >= NB_F) begin
            push_s       = 1'b1;
            push_data_s  = comb_s[OUT_WIDTH-1:0];
            push_bytes_s = BW'(NB);
            acc_d        = OUT_WIDTH'(comb_s[AW-1:OUT_WIDTH]);
            fill_d       = BW'(total_s - NB_F);
        end else if (flush_req_s && (ext_cnt_s == 4'd0) && (fill_q != {BW{1'b0}})) begin
            push_s       = 1'b1;
            push_data_s  = acc_q;
            push_bytes_s = fill_q;
            acc_d        = {OUT_WIDTH{1'b0}};
            fill_d       = {BW{1'b0}};
        end else begin
            acc_d  = comb_s[OUT_WIDTH-1:0];
            fill_d = BW'(total_s);
        end
    end

    // FIFO control: a pop at full frees the slot for a simultaneous push
    always_comb begin
        pop_s   = valid_q & m_ready;
        full_s  = (count_q == CW'(FIFO_DEPTH));
        wr_en_s = push_s & (~full_s | pop_s);
        count_d = count_q + CW'(wr_en_s) - CW'(pop_s);
    end

    // Packer state, FIFO pointers and recovered block registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= {OUT_WIDTH{1'b0}};
            fill_q   <= {BW{1'b0}};
            pend_q   <= 1'b0;
            rhdr_q   <= 2'b00;
            rdata_q  <= 64'd0;
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            fill_q   <= fill_d;
            pend_q   <= pend_d;
            rhdr_q   <= encoded_rx_hdr;
            rdata_q  <= rdata_s;
            wr_ptr_q <= wr_en_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_q <= pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
            count_q  <= count_d;
            valid_q  <= (count_d != {CW{1'b0}});
        end
    end

    // FIFO storage; contents are qualified by valid_q so no reset is needed
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_s) begin
            mem_data_q[wr_ptr_q]  <= push_data_s;
            mem_bytes_q[wr_ptr_q] <= push_bytes_s;
        end
    end

`ifdef IPG_RX_DROP_CNT_EN
    logic [15:0] drop_q;

    // Saturating count of words discarded at a full FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= 16'h0000;
        end else if (push_s && full_s && !pop_s && (drop_q != 16'hffff)) begin
            drop_q <= drop_q + 16'h0001;
        end else begin
            drop_q <= drop_q;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 16'h0000;
`endif

    assign recovered_rx_hdr  = rhdr_q;
    assign recovered_rx_data = rdata_q;
    assign m_data            = mem_data_q[rd_ptr_q];
    assign m_bytes           = mem_bytes_q[rd_ptr_q];
    assign m_valid           = valid_q;

endmodule

// File: tb/tb_ipg_rx_packer.sv
// Randomized bench for ipg_rx_packer against a byte-queue reference model (OUT_WIDTH=64, FIFO_DEPTH=8).
module tb_ipg_rx_packer;
    localparam int OW    = 64;
    localparam int DEPTH = 8;
    localparam int NB    = OW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    encoded_rx_hdr;
    logic [63:0]   encoded_rx_data;
    logic          flush;
    logic [1:0]    recovered_rx_hdr;
    logic [63:0]   recovered_rx_data;
    logic [OW-1:0] m_data;
    logic [3:0]    m_bytes;
    logic          m_valid;
    logic          m_ready;
    logic [15:0]   drop_cnt;

    ipg_rx_packer #(.OUT_WIDTH(OW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .encoded_rx_hdr(encoded_rx_hdr), .encoded_rx_data(encoded_rx_data), .flush(flush),
        .recovered_rx_hdr(recovered_rx_hdr), .recovered_rx_data(recovered_rx_data),
        .m_data(m_data), .m_bytes(m_bytes), .m_valid(m_valid), .m_ready(m_ready),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] d;
        int            b;
    } word_t;

    logic [7:0]  acc[$];
    word_t       fifo[$];
    bit          pend;
    int          exp_drop;
    logic [1:0]  exp_hdr;
    logic [63:0] exp_rdata;
    int          pass_cnt = 0;
    int          chk_cnt  = 0;

    task automatic check_value(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Lanes carrying IPG bytes for each control block type; lo > hi means none
    task automatic lanes(input logic [7:0] t, output int lo, output int hi);
        lo = 1; hi = 0;
        case (t)
            8'h1e:        begin lo = 1; hi = 7; end
            8'h2d, 8'h33: begin lo = 1; hi = 3; end
            8'h4b, 8'hb4: begin lo = 5; hi = 7; end
            8'h87:        begin lo = 2; hi = 7; end
            8'h99:        begin lo = 3; hi = 7; end
            8'haa:        begin lo = 4; hi = 7; end
            8'hcc:        begin lo = 6; hi = 7; end
            8'hd2:        begin lo = 7; hi = 7; end
            default:      begin lo = 1; hi = 0; end
        endcase
    endtask

    task automatic model_reset();
        acc.delete();
        fifo.delete();
        pend      = 1'b0;
        exp_drop  = 0;
        exp_hdr   = 2'b00;
        exp_rdata = 64'd0;
    endtask

    task automatic model_step(input logic [1:0] h, input logic [63:0] d, input logic fl, input logic rdy);
        int lo, hi, n, sz;
        bit pop, have_push;
        word_t w;
        exp_hdr   = h;
        exp_rdata = d;
        n = 0;
        if (h == 2'b01) begin
            lanes(d[7:0], lo, hi);
            for (int i = lo; i <= hi; i++) begin
                acc.push_back(d[8*i +: 8]);
                exp_rdata[8*i +: 8] = 8'h00;
                n++;
            end
        end
        pop = rdy && (fifo.size() > 0);
        have_push = 1'b0;
        w.d = '0;
        w.b = 0;
        if (acc.size() >= NB) begin
            have_push = 1'b1;
            w.b = NB;
            for (int i = 0; i < NB; i++) w.d[8*i +: 8] = acc.pop_front();
        end else if (n == 0 && (fl || pend) && acc.size() > 0) begin
            have_push = 1'b1;
            w.b = acc.size();
            for (int i = 0; i < w.b; i++) w.d[8*i +: 8] = acc.pop_front();
        end
        pend = (fl || pend) && (n > 0);
        sz = fifo.size();
        if (pop) void'(fifo.pop_front());
        if (have_push) begin
            if (sz < DEPTH || pop) fifo.push_back(w);
`ifdef IPG_RX_DROP_CNT_EN
            else if (exp_drop < 65535) exp_drop++;
`endif
        end
    endtask

    task automatic check_outputs();
        check_value("rx_hdr", recovered_rx_hdr, exp_hdr);
        check_value("rx_data", recovered_rx_data, exp_rdata);
        check_value("m_valid", m_valid, fifo.size() > 0);
        if (fifo.size() > 0) begin
            check_value("m_data", m_data, fifo[0].d);
            check_value("m_bytes", m_bytes, fifo[0].b);
        end
        check_value("drop_cnt", drop_cnt, exp_drop);
    endtask

    task automatic cycle(input logic [1:0] h, input logic [63:0] d, input logic fl, input logic rdy);
        encoded_rx_hdr  = h;
        encoded_rx_data = d;
        flush           = fl;
        m_ready         = rdy;
        model_step(h, d, fl, rdy);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        encoded_rx_hdr  = 2'b01;
        encoded_rx_data = {$urandom, $urandom};
        flush           = 1'b1;
        m_ready         = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] blk(input logic [7:0] t);
        return {$urandom, $urandom_range(0, 32'hffffff), t};
    endfunction

    logic [7:0] types [13] = '{8'h1e, 8'h2d, 8'h33, 8'h4b, 8'hb4, 8'h87, 8'h99,
                               8'haa, 8'hcc, 8'hd2, 8'h78, 8'h00, 8'h55};

    initial begin
        logic [7:0] t;
        logic [1:0] h;
        int rdy_pct;
        rst_n = 1'b0;
        model_reset();
        do_reset();

        cycle(2'b01, {56'h11223344556677, 8'h1e}, 1'b0, 1'b0);
        check_value("req029_rdata", recovered_rx_data, 64'h1e);
        cycle(2'b01, blk(8'h1e), 1'b0, 1'b0);
        cycle(2'b00, 64'd0, 1'b0, 1'b0);
        check_value("req030_bytes", m_bytes, 4'd8);
        cycle(2'b00, 64'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(2'b00, 64'd0, 1'b0, 1'b1);

        do_reset();
        cycle(2'b01, blk(8'hcc), 1'b0, 1'b1);
        cycle(2'b00, 64'd0, 1'b1, 1'b1);
        cycle(2'b00, 64'd0, 1'b0, 1'b0);
        check_value("req031_bytes", m_bytes, 4'd2);
        cycle(2'b00, 64'd0, 1'b0, 1'b1);

        do_reset();
        cycle(2'b01, blk(8'h87), 1'b1, 1'b1);
        cycle(2'b00, 64'd0, 1'b0, 1'b0);
        cycle(2'b00, 64'd0, 1'b1, 1'b0);
        check_value("req032_bytes", m_bytes, 4'd6);
        cycle(2'b00, 64'd0, 1'b0, 1'b1);

        cycle(2'b10, blk(8'h1e), 1'b0, 1'b1);
        cycle(2'b01, blk(8'h78), 1'b1, 1'b1);
        cycle(2'b00, 64'd0, 1'b1, 1'b1);

        do_reset();
        for (int i = 0; i < 12; i++) cycle(2'b01, blk(8'h1e), 1'b0, 1'b0);
`ifdef IPG_RX_DROP_CNT_EN
        check_value("req033_drop", drop_cnt, 16'd2);
`else
        check_value("req033_drop", drop_cnt, 16'd0);
`endif
        for (int i = 0; i < 10; i++) cycle(2'b00, 64'd0, 1'b0, 1'b1);

        for (int blkn = 0; blkn < 30; blkn++) begin
            rdy_pct = (blkn % 3 == 0) ? 15 : ((blkn % 3 == 1) ? 60 : 100);
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 599) == 0) do_reset();
                t = types[$urandom_range(0, 12)];
                if ($urandom_range(0, 12) == 0) t = 8'($urandom);
                h = ($urandom_range(0, 9) < 8) ? 2'b01 : 2'($urandom);
                if ($urandom_range(0, 5) == 0) h = 2'b00;
                cycle(h, blk(t), $urandom_range(0, 7) == 0, $urandom_range(1, 100) <= rdy_pct);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
